aclk_timekeeper: RTL and testbench

- Parametrised next-generation time-of-day counter for the alarm clock; replaces the fixed 24-hour HH:MM minute counter.
- Optional seconds field, runtime 12/24-hour mode with live conversion, validated time load, per-field adjust, and a day-rollover pulse.
- Outputs are BCD digits, feeding the display driver and the alarm comparator.

---
 rtl/aclk_pkg.sv | 21 ++
 rtl/aclk_timekeeper_if.sv | 39 +++
 rtl/aclk_bcd_mod60.sv | 45 ++++
 rtl/aclk_timekeeper.sv | 170 +++++++++++++++++
 tb/tb_aclk_timekeeper.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/aclk_pkg.sv
// Shared types, limits and BCD helpers for the alarm-clock timekeeper.
package aclk_pkg;

    typedef logic [3:0] bcd_t;

    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MIN = 1;
    localparam int HR12_MAX = 12;

    function automatic logic is_valid_bcd(input bcd_t d);
        return d <= 4'd9;
    endfunction

    // Two BCD digits to binary; 99 is the largest possible result, so 7 bits suffice.
    function automatic logic [6:0] bcd_to_bin(input bcd_t ms, input bcd_t ls);
        return {3'b000, ms} * 7'd10 + {3'b000, ls};
    endfunction

endpackage

// File: rtl/aclk_timekeeper_if.sv
// Control and time-display bundle between the timekeeper and its users.
interface aclk_timekeeper_if;
    import aclk_pkg::*;

    logic tick;
    logic mode_12h;
    logic load_new_c;
    bcd_t new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec;
    logic new_pm;
    logic adj_hr;
    logic adj_min;
    bcd_t current_time_ms_hr, current_time_ls_hr;
    bcd_t current_time_ms_min, current_time_ls_min;
    bcd_t current_time_ms_sec, current_time_ls_sec;
    logic pm;
    logic day_rollover;
    logic load_err;

    modport slave (
        input  tick, mode_12h, load_new_c,
        input  new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec,
        input  new_pm, adj_hr, adj_min,
        output current_time_ms_hr, current_time_ls_hr,
        output current_time_ms_min, current_time_ls_min,
        output current_time_ms_sec, current_time_ls_sec,
        output pm, day_rollover, load_err
    );

    modport master (
        output tick, mode_12h, load_new_c,
        output new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec,
        output new_pm, adj_hr, adj_min,
        input  current_time_ms_hr, current_time_ls_hr,
        input  current_time_ms_min, current_time_ls_min,
        input  current_time_ms_sec, current_time_ls_sec,
        input  pm, day_rollover, load_err
    );

endinterface

// File: rtl/aclk_bcd_mod60.sv
// Two-digit BCD 00-59 counter; carry_out flags the increment that wraps 59 -> 00.
module aclk_bcd_mod60
    import aclk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    input  logic load,
    input  bcd_t load_ms,
    input  bcd_t load_ls,
    output bcd_t ms,
    output bcd_t ls,
    output logic carry_out
);

    logic at_max;

    assign at_max    = (bcd_to_bin(ms, ls) == 7'(MIN_MAX));
    assign carry_out = inc && at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms <= 4'd0;
            ls <= 4'd0;
        end else if (clear) begin
            ms <= 4'd0;
            ls <= 4'd0;
        end else if (load) begin
            ms <= load_ms;
            ls <= load_ls;
        end else if (inc) begin
            if (at_max) begin
                ms <= 4'd0;
                ls <= 4'd0;
            end else if (ls == 4'd9) begin
                ms <= ms + 4'd1;
                ls <= 4'd0;
            end else begin
                ls <= ls + 4'd1;
            end
        end
    end

endmodule

// File: rtl/aclk_timekeeper.sv
// Time-of-day counter: BCD HH:MM(:SS) with 12/24-hour mode, validated load and adjust.
module aclk_timekeeper
    import aclk_pkg::*;
#(
    parameter bit SECONDS_EN = 1'b1,
    parameter bit ADJ_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    aclk_timekeeper_if.slave  bus
);

    logic [4:0] hr;
    logic       pm_q, mode_q, rollover_q, err_q;
    logic       adj_hr_en, adj_min_en;
    logic       do_load, do_mode, do_adj, do_tick;
    logic [6:0] new_hr, new_min, new_sec;
    logic       load_ok, digits_ok, hr_ok;
    logic       sec_carry, min_inc, min_carry, sec_clear, load_fields;
    bcd_t       sec_ms, sec_ls, min_ms, min_ls, hr_ms, hr_ls;

    assign adj_hr_en  = ADJ_EN && bus.adj_hr;
    assign adj_min_en = ADJ_EN && bus.adj_min;

    // Only the highest-priority event of a cycle acts; the others are dropped.
    assign do_load = bus.load_new_c;
    assign do_mode = !do_load && (bus.mode_12h != mode_q);
    assign do_adj  = !do_load && !do_mode && (adj_hr_en || adj_min_en);
    assign do_tick = !do_load && !do_mode && !do_adj && bus.tick;

    assign new_hr  = bcd_to_bin(bus.new_ms_hr, bus.new_ls_hr);
    assign new_min = bcd_to_bin(bus.new_ms_min, bus.new_ls_min);
    assign new_sec = bcd_to_bin(bus.new_ms_sec, bus.new_ls_sec);

    assign digits_ok = is_valid_bcd(bus.new_ms_hr)  && is_valid_bcd(bus.new_ls_hr)  &&
                       is_valid_bcd(bus.new_ms_min) && is_valid_bcd(bus.new_ls_min) &&
                       (!SECONDS_EN || (is_valid_bcd(bus.new_ms_sec) && is_valid_bcd(bus.new_ls_sec)));
    assign hr_ok     = mode_q ? (new_hr >= 7'(HR12_MIN) && new_hr <= 7'(HR12_MAX))
                              : (new_hr <= 7'(HR24_MAX));
    assign load_ok   = digits_ok && hr_ok && (new_min <= 7'(MIN_MAX)) &&
                       (!SECONDS_EN || (new_sec <= 7'(SEC_MAX)));

    assign load_fields = do_load && load_ok;
    assign sec_clear   = do_adj && adj_min_en;
    assign min_inc     = sec_carry || (do_adj && adj_min_en);

    generate
        if (SECONDS_EN) begin : g_sec
            aclk_bcd_mod60 u_sec (
                .clk       (clk),
                .reset     (reset),
                .inc       (do_tick),
                .clear     (sec_clear),
                .load      (load_fields),
                .load_ms   (bus.new_ms_sec),
                .load_ls   (bus.new_ls_sec),
                .ms        (sec_ms),
                .ls        (sec_ls),
                .carry_out (sec_carry)
            );
        end else begin : g_no_sec
            assign sec_ms    = 4'd0;
            assign sec_ls    = 4'd0;
            assign sec_carry = do_tick;
        end
    endgenerate

    aclk_bcd_mod60 u_min (
        .clk       (clk),
        .reset     (reset),
        .inc       (min_inc),
        .clear     (1'b0),
        .load      (load_fields),
        .load_ms   (bus.new_ms_min),
        .load_ls   (bus.new_ls_min),
        .ms        (min_ms),
        .ls        (min_ls),
        .carry_out (min_carry)
    );

    function automatic logic [4:0] hr_next(input logic [4:0] h, input logic m12);
        if (m12)
            return (h == 5'(HR12_MAX)) ? 5'(HR12_MIN) : h + 5'd1;
        else
            return (h == 5'(HR24_MAX)) ? 5'd0 : h + 5'd1;
    endfunction

    // Hours kept in binary as displayed (0-23 or 1-12); pm only ever set in 12h mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            hr         <= bus.mode_12h ? 5'(HR12_MAX) : 5'd0;
            pm_q       <= 1'b0;
            mode_q     <= bus.mode_12h;
            rollover_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rollover_q <= 1'b0;
            err_q      <= 1'b0;
            if (do_load) begin
                if (load_ok) begin
                    hr   <= new_hr[4:0];
                    pm_q <= mode_q && bus.new_pm;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (do_mode) begin
                mode_q <= bus.mode_12h;
                if (bus.mode_12h) begin
                    if (hr == 5'd0) begin
                        hr   <= 5'(HR12_MAX);
                        pm_q <= 1'b0;
                    end else if (hr < 5'd12) begin
                        pm_q <= 1'b0;
                    end else if (hr == 5'd12) begin
                        pm_q <= 1'b1;
                    end else begin
                        hr   <= hr - 5'd12;
                        pm_q <= 1'b1;
                    end
                end else begin
                    pm_q <= 1'b0;
                    if (pm_q && hr != 5'd12)
                        hr <= hr + 5'd12;
                    else if (!pm_q && hr == 5'd12)
                        hr <= 5'd0;
                end
            end else if (do_adj) begin
                if (adj_hr_en) begin
                    hr <= hr_next(hr, mode_q);
                    if (mode_q && hr == 5'd11)
                        pm_q <= !pm_q;
                end
            end else if (do_tick && min_carry) begin
                hr <= hr_next(hr, mode_q);
                if (mode_q) begin
                    if (hr == 5'd11) begin
                        pm_q       <= !pm_q;
                        rollover_q <= pm_q;
                    end
                end else begin
                    rollover_q <= (hr == 5'(HR24_MAX));
                end
            end
        end
    end

    // Low nibble of hr minus 10 or 20 gives the units digit without a wide subtract.
    always_comb begin
        hr_ms = 4'd0;
        hr_ls = hr[3:0];
        if (hr >= 5'd20) begin
            hr_ms = 4'd2;
            hr_ls = hr[3:0] - 4'd4;
        end else if (hr >= 5'd10) begin
            hr_ms = 4'd1;
            hr_ls = hr[3:0] - 4'd10;
        end
    end

    assign bus.current_time_ms_hr  = hr_ms;
    assign bus.current_time_ls_hr  = hr_ls;
    assign bus.current_time_ms_min = min_ms;
    assign bus.current_time_ls_min = min_ls;
    assign bus.current_time_ms_sec = sec_ms;
    assign bus.current_time_ls_sec = sec_ls;
    assign bus.pm                  = pm_q;
    assign bus.day_rollover        = rollover_q;
    assign bus.load_err            = err_q;

endmodule

// File: tb/tb_aclk_timekeeper.sv
// Directed self-checking bench for aclk_timekeeper; times are compared as packed BCD HHMMSS.
module tb_aclk_timekeeper;
    import aclk_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    aclk_timekeeper_if tk_if ();

    aclk_timekeeper #(
        .SECONDS_EN (1'b1),
        .ADJ_EN     (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tk_if)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] curTime();
        return {tk_if.current_time_ms_hr, tk_if.current_time_ls_hr,
                tk_if.current_time_ms_min, tk_if.current_time_ls_min,
                tk_if.current_time_ms_sec, tk_if.current_time_ls_sec};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setNew(input logic [23:0] t, input logic p);
        {tk_if.new_ms_hr, tk_if.new_ls_hr, tk_if.new_ms_min,
         tk_if.new_ls_min, tk_if.new_ms_sec, tk_if.new_ls_sec} = t;
        tk_if.new_pm = p;
    endtask

    // One clock with the given strobes; outputs are sampled 1 ns after the edge.
    task automatic applyStimulus(input logic t, input logic ld, input logic ah, input logic am);
        tk_if.tick       = t;
        tk_if.load_new_c = ld;
        tk_if.adj_hr     = ah;
        tk_if.adj_min    = am;
        @(posedge clk);
        #1;
        tk_if.tick       = 1'b0;
        tk_if.load_new_c = 1'b0;
        tk_if.adj_hr     = 1'b0;
        tk_if.adj_min    = 1'b0;
    endtask

    task automatic loadTime(input logic [23:0] t, input logic p);
        setNew(t, p);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        tk_if.mode_12h = 1'b1;
        setNew(24'h000000, 1'b0);
        tk_if.tick = 1'b0;
        tk_if.load_new_c = 1'b0;
        tk_if.adj_hr = 1'b0;
        tk_if.adj_min = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("reset_time_12h", 32'(curTime()), 32'h120000);
        checkOutput("reset_pm", 32'(tk_if.pm), 32'h0);
        checkOutput("reset_rollover", 32'(tk_if.day_rollover), 32'h0);
        checkOutput("reset_load_err", 32'(tk_if.load_err), 32'h0);
        reset = 1'b0;

        tk_if.mode_12h = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mode_12am_to_24", 32'(curTime()), 32'h000000);

        // 24h day rollover
        loadTime(24'h235958, 1'b0);
        checkOutput("load_235958", 32'(curTime()), 32'h235958);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tick_235959", 32'(curTime()), 32'h235959);
        checkOutput("no_rollover_235959", 32'(tk_if.day_rollover), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tick_midnight_24h", 32'(curTime()), 32'h000000);
        checkOutput("rollover_24h", 32'(tk_if.day_rollover), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rollover_one_cycle", 32'(tk_if.day_rollover), 32'h0);
        checkOutput("hold_without_tick", 32'(curTime()), 32'h000000);
        loadTime(24'h095959, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hr_09_to_10", 32'(curTime()), 32'h100000);
        loadTime(24'h195959, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hr_19_to_20", 32'(curTime()), 32'h200000);

        // 12h noon and midnight
        loadTime(24'h000000, 1'b0);
        tk_if.mode_12h = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mode_00_to_12am", 32'(curTime()), 32'h120000);
        checkOutput("mode_00_to_12am_pm", 32'(tk_if.pm), 32'h0);
        loadTime(24'h115959, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("noon_time", 32'(curTime()), 32'h120000);
        checkOutput("noon_pm", 32'(tk_if.pm), 32'h1);
        checkOutput("noon_no_rollover", 32'(tk_if.day_rollover), 32'h0);
        loadTime(24'h115959, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midnight_12h_time", 32'(curTime()), 32'h120000);
        checkOutput("midnight_12h_pm", 32'(tk_if.pm), 32'h0);
        checkOutput("midnight_12h_rollover", 32'(tk_if.day_rollover), 32'h1);
        loadTime(24'h125959, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hr_12_to_01", 32'(curTime()), 32'h010000);
        checkOutput("hr_12_to_01_pm", 32'(tk_if.pm), 32'h1);
        checkOutput("hr_12_to_01_no_roll", 32'(tk_if.day_rollover), 32'h0);

        // Rejected loads
        loadTime(24'h003000, 1'b0);
        checkOutput("bad_hr00_12h_err", 32'(tk_if.load_err), 32'h1);
        checkOutput("bad_hr00_12h_time", 32'(curTime()), 32'h010000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("load_err_one_cycle", 32'(tk_if.load_err), 32'h0);
        loadTime(24'h123A00, 1'b0);
        checkOutput("bad_digit_err", 32'(tk_if.load_err), 32'h1);
        checkOutput("bad_digit_time", 32'(curTime()), 32'h010000);
        checkOutput("bad_digit_pm", 32'(tk_if.pm), 32'h1);
        tk_if.mode_12h = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mode_1pm_to_13", 32'(curTime()), 32'h130000);
        checkOutput("mode_to24_pm_clear", 32'(tk_if.pm), 32'h0);
        loadTime(24'h240000, 1'b0);
        checkOutput("bad_hr24_err", 32'(tk_if.load_err), 32'h1);
        checkOutput("bad_hr24_time", 32'(curTime()), 32'h130000);
        setNew(24'h101010, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("load_beats_tick", 32'(curTime()), 32'h101010);

        // Mode conversion
        loadTime(24'h174500, 1'b0);
        tk_if.mode_12h = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mode_17_to_5pm", 32'(curTime()), 32'h054500);
        checkOutput("mode_17_to_5pm_pm", 32'(tk_if.pm), 32'h1);
        loadTime(24'h121000, 1'b0);
        tk_if.mode_12h = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mode_12am_10_to_00", 32'(curTime()), 32'h001000);

        // Adjust
        loadTime(24'h095930, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("adj_min_wrap", 32'(curTime()), 32'h090000);
        tk_if.mode_12h = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        loadTime(24'h113000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("adj_hr_11_to_12", 32'(curTime()), 32'h123000);
        checkOutput("adj_hr_pm_toggle", 32'(tk_if.pm), 32'h1);
        checkOutput("adj_hr_no_rollover", 32'(tk_if.day_rollover), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("adj_beats_tick", 32'(curTime()), 32'h013000);
        checkOutput("adj_12_to_01_pm", 32'(tk_if.pm), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("adj_both", 32'(curTime()), 32'h023100);

        tk_if.tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        tk_if.tick = 1'b0;
        checkOutput("tick_held_3", 32'(curTime()), 32'h023103);

        // Reset overrides a concurrent load
        reset = 1'b1;
        setNew(24'h050000, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_beats_load", 32'(curTime()), 32'h120000);
        checkOutput("reset_beats_load_pm", 32'(tk_if.pm), 32'h0);
        checkOutput("reset_beats_load_err", 32'(tk_if.load_err), 32'h0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
